// File: rtl/voter_pkg.sv
// Shared constants for the four-member majority voter.
// It holds the vote thresholds, the result bit positions and the one-hot result codes.
package voter_pkg;

    localparam int N_VOTERS = 4;
    localparam int PASS_MIN = 3;
    localparam int TIE_CNT  = 2;

    // Bit positions on the O[3:1] result bus.
    localparam int O_PASS = 3;
    localparam int O_TIE  = 2;
    localparam int O_FAIL = 1;

    localparam logic [3:1] RES_NONE = 3'b000;
    localparam logic [3:1] RES_PASS = 3'b100;
    localparam logic [3:1] RES_TIE  = 3'b010;
    localparam logic [3:1] RES_FAIL = 3'b001;

endpackage

// File: rtl/voter_popcount4.sv
// Counts the YES ballots among four independent 1-bit votes.
// The result is in the range 0..4, and the logic is purely combinational.
module voter_popcount4
    import voter_pkg::*;
(
    input  logic [N_VOTERS-1:0] ballots_i,
    output logic [2:0]          cnt_o
);

    assign cnt_o = {2'b00, ballots_i[0]} + {2'b00, ballots_i[1]}
                 + {2'b00, ballots_i[2]} + {2'b00, ballots_i[3]};

endmodule

// File: rtl/voter_if.sv
// Four-member majority voter.
// It drives a registered one-hot PASS/TIE/FAIL result, with exactly one cycle of latency from the ballots.
module voter_if
    import voter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] I,
    output logic [3:1] O
);

    logic [2:0] yes_cnt;
    logic [3:1] result_d;
    logic [3:1] result_q;

    voter_popcount4 u_popcount (
        .ballots_i (I),
        .cnt_o     (yes_cnt)
    );

    always_comb begin
        result_d = RES_FAIL;
        if (yes_cnt >= 3'(PASS_MIN)) begin
            result_d = RES_PASS;
        end else if (yes_cnt == 3'(TIE_CNT)) begin
            result_d = RES_TIE;
        end
    end

    // All-zero means "no decision yet"; it is only seen from reset up to the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= RES_NONE;
        end else begin
            result_q <= result_d;
        end
    end

    assign O = result_q;

endmodule

// File: tb/tb_voter_if.sv
// Directed bench for voter_if.
// Expected results come from an independent ballot-count model and pass through a scoreboard queue.
module tb_voter_if;

  logic       clk;
  logic       rst;
  logic [3:0] I;
  logic [3:1] O;

  logic [2:0] exp_q[$];
  int         pass_cnt;
  int         total_cnt;

  voter_if dut (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .O   (O)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic logic [2:0] model(input logic [3:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 4; b++) begin
      if (v[b]) n++;
    end
    if (n >= 3)      return 3'b100;
    else if (n == 2) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%b required=%b", tag, obs, exp);
  endtask

  task automatic check_onehot(input string tag);
    logic oh;
    oh = $onehot(O);
    total_cnt++;
    assert (oh === 1'b1) pass_cnt++;
    else $error("FAIL %s_onehot: observed O=%b required exactly one bit set", tag, O);
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    I = v;
    exp_q.push_back(model(v));
  endtask

  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, O, 3'bxxx);
    end else begin
      check(tag, O, exp_q.pop_front());
      check_onehot(tag);
    end
  endtask

  task automatic step(input logic [3:0] v, input string tag);
    drive(v);
    collect(tag);
  endtask

  initial begin
    logic [3:0] rv;
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    I   = 4'b1111;

    // Reset holds O at zero while the clock runs and the ballots are all YES.
    #2;
    check("reset_async", O, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", O, 3'b000);
    end
    drive(4'b1111);
    rst = 1'b0;
    #1;
    check("reset_release_pre_edge", O, 3'b000);
    collect("reset_release");

    // Exhaustive sweep, one value per cycle.
    for (int v = 0; v < 16; v++) begin
      step(4'(v), $sformatf("sweep_%04b", 4'(v)));
    end

    // Latency: O keeps the old result until the edge that samples the new ballots.
    step(4'b0000, "latency_base");
    drive(4'b1111);
    #1;
    check("latency_pre_edge", O, 3'b001);
    collect("latency_post_edge");

    // Hold: constant ballots keep O constant.
    for (int k = 0; k < 5; k++) begin
      step(4'b0101, "hold_0101");
    end

    // Mid-run reset.
    step(4'b1110, "midrst_before");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_async_clear", O, 3'b000);
    @(posedge clk);
    #1;
    check("midrst_held_edge", O, 3'b000);
    drive(4'b0001);
    rst = 1'b0;
    collect("midrst_resume");

    // Permutation invariance.
    step(4'b0011, "perm_0011");
    step(4'b1100, "perm_1100");
    step(4'b1010, "perm_1010");

    // Random ballots, one per cycle.
    for (int k = 0; k < 20; k++) begin
      rv = 4'($urandom_range(0, 15));
      step(rv, $sformatf("rand_%04b", rv));
    end

    total_cnt++;
    assert (exp_q.size() == 0) pass_cnt++;
    else $error("FAIL scoreboard_drain: observed=%0d left required=0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
